rx_udp: RTL and testbench

Receive-side UDP stage. It consumes the IPv4 payload byte stream (`rx_data_udp`/`rx_data`) produced by the IPv4 receive stage and parses the 8-byte UDP header. Datagrams addressed to the configured port have their payload forwarded byte-by-byte to the application. It strips trailing Ethernet/IP padding using the UDP length field, and flags truncated or malformed datagrams.

---
 rtl/rx_udp.sv | 154 +++++++++++++++
 tb/tb_rx_udp.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/rx_udp.sv
// Receive-side UDP parser: captures the 8-byte header, forwards payload for the
// configured port, strips trailing padding via the length field, flags truncation.
module rx_udp #(
  parameter int unsigned OCT = 8
) (
  input  logic           RX_CLK,
  input  logic           rst,
  input  logic [15:0]    port_num,
  input  logic           rx_data_udp,
  input  logic [OCT-1:0] rx_data,
  output logic [15:0]    rx_src_port,
  output logic [15:0]    rx_dst_port,
  output logic [15:0]    rx_udp_len,
  output logic [15:0]    rx_udp_checksum,
  output logic           rx_udp_payload_valid,
  output logic [OCT-1:0] rx_udp_payload,
  output logic           rx_udp_done,
  output logic           rx_udp_err
);

  localparam int unsigned FW      = 16;
  localparam logic [FW-1:0] HDR_LEN = FW'(8);

  typedef enum logic [2:0] {
    S_SRC_PORT, S_DST_PORT, S_LEN, S_CSUM, S_PAYLOAD, S_TRAIL, S_DROP
  } state_t;

  state_t          state_q, state_d;
  logic            cnt_q, cnt_d;
  logic            match_q, match_d;
  logic [FW-1:0]   remain_q, remain_d;
  logic [FW-1:0]   src_q, src_d, dst_q, dst_d, len_q, len_d, csum_q, csum_d;
  logic [OCT-1:0]  payload_q, payload_d;
  logic            valid_q, valid_d, done_q, done_d, err_q, err_d;
  logic [FW-1:0]   dst_full;

  assign dst_full = FW'({dst_q[7:0], rx_data});

  always_ff @(posedge RX_CLK) begin
    if (rst) begin
      state_q   <= S_SRC_PORT;
      cnt_q     <= 1'b0;
      match_q   <= 1'b0;
      remain_q  <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      csum_q    <= '0;
      payload_q <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      match_q   <= match_d;
      remain_q  <= remain_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      len_q     <= len_d;
      csum_q    <= csum_d;
      payload_q <= payload_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    match_d   = match_q;
    remain_d  = remain_q;
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    csum_d    = csum_q;
    payload_d = payload_q;
    valid_d   = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;

    if (!rx_data_udp) begin
      // End of the IPv4 payload: anything short of a complete header/payload is truncation
      state_d = S_SRC_PORT;
      cnt_d   = 1'b0;
      match_d = 1'b0;
      case (state_q)
        S_SRC_PORT:                          err_d = cnt_q;
        S_DST_PORT, S_LEN, S_CSUM, S_PAYLOAD: err_d = 1'b1;
        default:                             err_d = 1'b0;
      endcase
    end else begin
      case (state_q)
        S_SRC_PORT: begin
          src_d = FW'({src_q[7:0], rx_data});
          cnt_d = ~cnt_q;
          if (cnt_q) state_d = S_DST_PORT;
        end
        S_DST_PORT: begin
          dst_d = dst_full;
          cnt_d = ~cnt_q;
          if (cnt_q) begin
            match_d = (dst_full == port_num);
            state_d = S_LEN;
          end
        end
        S_LEN: begin
          len_d = FW'({len_q[7:0], rx_data});
          cnt_d = ~cnt_q;
          if (cnt_q) state_d = S_CSUM;
        end
        S_CSUM: begin
          csum_d = FW'({csum_q[7:0], rx_data});
          cnt_d  = ~cnt_q;
          if (cnt_q) begin
            if (len_q < HDR_LEN) begin
              err_d   = 1'b1;
              state_d = S_DROP;
            end else if (!match_q) begin
              state_d = S_DROP;
            end else if (len_q == HDR_LEN) begin
              done_d  = 1'b1;
              state_d = S_TRAIL;
            end else begin
              remain_d = len_q - HDR_LEN;
              state_d  = S_PAYLOAD;
            end
          end
        end
        S_PAYLOAD: begin
          payload_d = rx_data;
          valid_d   = 1'b1;
          remain_d  = remain_q - FW'(1);
          if (remain_q == FW'(1)) begin
            done_d  = 1'b1;
            state_d = S_TRAIL;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  assign rx_src_port          = src_q;
  assign rx_dst_port          = dst_q;
  assign rx_udp_len           = len_q;
  assign rx_udp_checksum      = csum_q;
  assign rx_udp_payload_valid = valid_q;
  assign rx_udp_payload       = payload_q;
  assign rx_udp_done          = done_q;
  assign rx_udp_err           = err_q;

endmodule

// File: tb/tb_rx_udp.sv
// Bench for rx_udp: directed and random datagrams checked against an
// event-level model derived from the header fields and byte count.
module tb_rx_udp;

  logic        RX_CLK = 1'b0;
  logic        rst;
  logic [15:0] port_num;
  logic        rx_data_udp;
  logic [7:0]  rx_data;
  logic [15:0] rx_src_port, rx_dst_port, rx_udp_len, rx_udp_checksum;
  logic        rx_udp_payload_valid, rx_udp_done, rx_udp_err;
  logic [7:0]  rx_udp_payload;

  int checks = 0;
  int errors = 0;
  logic [7:0] dq[$];

  always #5 RX_CLK = ~RX_CLK;

  rx_udp #(.OCT(8)) dut (
    .RX_CLK(RX_CLK), .rst(rst), .port_num(port_num),
    .rx_data_udp(rx_data_udp), .rx_data(rx_data),
    .rx_src_port(rx_src_port), .rx_dst_port(rx_dst_port),
    .rx_udp_len(rx_udp_len), .rx_udp_checksum(rx_udp_checksum),
    .rx_udp_payload_valid(rx_udp_payload_valid), .rx_udp_payload(rx_udp_payload),
    .rx_udp_done(rx_udp_done), .rx_udp_err(rx_udp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one edge's inputs, then sample the registered outputs just after it.
  task automatic step(input logic v, input logic [7:0] d);
    rx_data_udp = v;
    rx_data     = d;
    @(posedge RX_CLK);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_src"},   32'(rx_src_port), 32'h0);
    chk({tag, "_dst"},   32'(rx_dst_port), 32'h0);
    chk({tag, "_len"},   32'(rx_udp_len), 32'h0);
    chk({tag, "_csum"},  32'(rx_udp_checksum), 32'h0);
    chk({tag, "_valid"}, 32'(rx_udp_payload_valid), 32'h0);
    chk({tag, "_pay"},   32'(rx_udp_payload), 32'h0);
    chk({tag, "_done"},  32'(rx_udp_done), 32'h0);
    chk({tag, "_err"},   32'(rx_udp_err), 32'h0);
  endtask

  task automatic build_hdr(input logic [15:0] s, input logic [15:0] d,
                           input logic [15:0] l, input logic [15:0] c);
    dq.delete();
    dq.push_back(s[15:8]); dq.push_back(s[7:0]);
    dq.push_back(d[15:8]); dq.push_back(d[7:0]);
    dq.push_back(l[15:8]); dq.push_back(l[7:0]);
    dq.push_back(c[15:8]); dq.push_back(c[7:0]);
  endtask

  // Send dq as one datagram followed by idle cycles; expectations come from
  // the header contents and the number of bytes actually delivered.
  task automatic run_dgram(input string tag);
    int n, p, f, done_c, err_c, nfwd, ndone, nerr;
    logic [15:0] l, d;
    logic m;
    n = dq.size();
    l = (n >= 6) ? {dq[4], dq[5]} : 16'h0;
    d = (n >= 4) ? {dq[2], dq[3]} : 16'h0;
    m = (n >= 4) && (d == port_num);
    p = (n >= 8 && m && l > 16'd8) ? int'(l) - 8 : 0;
    f = (n - 8 < p) ? n - 8 : p;
    if (f < 0) f = 0;
    done_c = -1;
    err_c  = -1;
    if (n >= 8 && m && l == 16'd8) done_c = 7;
    if (p > 0 && n - 8 >= p) done_c = 8 + p - 1;
    if (n < 8) err_c = n;
    else if (l < 16'd8) err_c = 7;
    else if (m && p > 0 && n - 8 < p) err_c = n;
    nfwd = 0; ndone = 0; nerr = 0;
    for (int c = 0; c < n + 3; c++) begin
      if (c < n) step(1'b1, dq[c]);
      else       step(1'b0, 8'h00);
      chk({tag, "_valid"}, 32'(rx_udp_payload_valid), 32'(c >= 8 && c < 8 + f));
      if (c >= 8 && c < 8 + f) chk({tag, "_byte"}, 32'(rx_udp_payload), 32'(dq[c]));
      chk({tag, "_done"}, 32'(rx_udp_done), 32'(c == done_c));
      chk({tag, "_err"},  32'(rx_udp_err),  32'(c == err_c));
    end
    if (n >= 8) begin
      chk({tag, "_src"},  32'(rx_src_port),     32'({dq[0], dq[1]}));
      chk({tag, "_dstp"}, 32'(rx_dst_port),     32'(d));
      chk({tag, "_len"},  32'(rx_udp_len),      32'(l));
      chk({tag, "_csum"}, 32'(rx_udp_checksum), 32'({dq[6], dq[7]}));
    end
  endtask

  initial begin
    int kind, total, sz;
    logic [15:0] ln;
    rst = 1'b1; rx_data_udp = 1'b0; rx_data = 8'h00; port_num = 16'h04D2;
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    chk_all_zero("reset");
    rst = 1'b0;

    build_hdr(16'h1F90, 16'h04D2, 16'h000C, 16'hBEEF);
    dq.push_back(8'hDE); dq.push_back(8'hAD); dq.push_back(8'hBE); dq.push_back(8'hEF);
    run_dgram("basic");

    build_hdr(16'h1F90, 16'h04D3, 16'h000C, 16'hBEEF);
    dq.push_back(8'hDE); dq.push_back(8'hAD); dq.push_back(8'hBE); dq.push_back(8'hEF);
    run_dgram("nomatch");

    build_hdr(16'h1111, 16'h04D2, 16'h000A, 16'h2222);
    dq.push_back(8'h11); dq.push_back(8'h22); dq.push_back(8'h33); dq.push_back(8'h44);
    run_dgram("padding");

    build_hdr(16'h3333, 16'h04D2, 16'h0008, 16'h4444);
    run_dgram("len8");

    build_hdr(16'h5555, 16'h04D2, 16'h0005, 16'h6666);
    run_dgram("len5");

    build_hdr(16'h7777, 16'h04D2, 16'h0010, 16'h8888);
    dq.push_back(8'hA1); dq.push_back(8'hA2); dq.push_back(8'hA3);
    run_dgram("trunc");

    build_hdr(16'h9999, 16'h04D2, 16'hFFFF, 16'hAAAA);
    for (int i = 0; i < 20; i++) dq.push_back(8'(i + 1));
    run_dgram("len_max");

    build_hdr(16'hBBBB, 16'h04D2, 16'h0010, 16'hCCCC);
    for (int i = 0; i < 3; i++) step(1'b1, dq[i]);
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h50 + i));
    rst = 1'b1;
    step(1'b1, 8'h99);
    chk_all_zero("midrst");
    rst = 1'b0;
    step(1'b0, 8'h00);
    chk("midrst_idle_err",  32'(rx_udp_err),  32'h0);
    chk("midrst_idle_done", 32'(rx_udp_done), 32'h0);

    build_hdr(16'h1F90, 16'h04D2, 16'h000C, 16'hBEEF);
    dq.push_back(8'hDE); dq.push_back(8'hAD); dq.push_back(8'hBE); dq.push_back(8'hEF);
    run_dgram("after_rst");

    for (int i = 0; i < 60; i++) begin
      port_num = 16'($urandom);
      kind = int'($urandom_range(0, 3));
      case (kind)
        0:       ln = 16'($urandom_range(0, 7));
        1:       ln = 16'd8;
        2:       ln = 16'(8 + $urandom_range(1, 24));
        default: ln = 16'hFFFF;
      endcase
      build_hdr(16'($urandom), ($urandom_range(0, 3) != 0) ? port_num : 16'($urandom),
                ln, 16'($urandom));
      if (kind == 2)      total = int'(ln) + int'($urandom_range(0, 4));
      else if (kind == 3) total = 8 + int'($urandom_range(1, 30));
      else                total = 8 + int'($urandom_range(0, 3));
      while (dq.size() < total) dq.push_back(8'($urandom));
      if ($urandom_range(0, 4) == 0) begin
        sz = int'($urandom_range(1, dq.size()));
        while (dq.size() > sz) void'(dq.pop_back());
      end
      run_dgram($sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
